mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between two requesters: port 0 is the multicycle core (fetch and load/store traffic) and port 1 is the program loader/debug DMA.
- Sits between the requesters and the memory. It latches each accepted request, sequences one memory access over a fixed read latency, and returns a one-cycle ack with read data.
- Arbitration is round-robin, with the core winning the first tie after reset.

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between the core (port 0) and loader (port 1).
// Latches a request, issues one mem_en, waits MEM_LAT cycles for read data, then acks.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_id
);
  localparam logic [3:0] LAT = 4'(MEM_LAT);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic last_gnt, last_n, gnt_n, pick;
  logic ack0_n, ack1_n, en_n, we_n, busy_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wd_n, rd_n;
  // a tie goes to whichever port did not win last time
  assign pick = (req0 & req1) ? ~last_gnt : req1;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    last_n = last_gnt;
    gnt_n = gnt_id;
    ack0_n = 1'b0;
    ack1_n = 1'b0;
    en_n = 1'b0;
    we_n = mem_we;
    addr_n = mem_addr;
    wd_n = mem_wdata;
    rd_n = rdata;
    busy_n = busy;
    case (state)
      IDLE: if (req0 | req1) begin
        state_n = ACCESS;
        cnt_n = 4'd0;
        last_n = pick;
        gnt_n = pick;
        en_n = 1'b1;
        busy_n = 1'b1;
        we_n = pick ? we1 : we0;
        addr_n = pick ? addr1 : addr0;
        wd_n = pick ? wdata1 : wdata0;
      end
      ACCESS: begin
        cnt_n = cnt + 4'd1;
        if (cnt == LAT) begin
          state_n = DONE;
          ack0_n = ~gnt_id;
          ack1_n = gnt_id;
          rd_n = mem_we ? rdata : mem_rdata;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      last_gnt <= 1'b1;
      gnt_id <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      last_gnt <= last_n;
      gnt_id <= gnt_n;
      ack0 <= ack0_n;
      ack1 <= ack1_n;
      mem_en <= en_n;
      mem_we <= we_n;
      mem_addr <= addr_n;
      mem_wdata <= wd_n;
      rdata <= rd_n;
      busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level schedule model.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  logic clk = 0, reset = 1;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic ack0, ack1, mem_en, mem_we, busy, gnt_id;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem_arr [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] pipe [LAT];
  int tests = 0, fails = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(int a);
    return (a * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  // memory: read data appears LAT cycles after mem_en, junk otherwise
  assign mem_rdata = pipe[LAT-1];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_arr[mem_addr[9:0]] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[9:0]] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    tick; tick;
    reset = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    tick; tick;
    tests++;
    if ({ack0, ack1, mem_en, mem_we, busy, gnt_id} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 000000", {ack0, ack1, mem_en, mem_we, busy, gnt_id});
    end
    tests++;
    if (mem_addr !== 0 || mem_wdata !== 0) begin
      fails++; $display("FAIL reset_mem: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
    end
    tests++;
    if (rdata !== 0) begin
      fails++; $display("FAIL reset_rdata: got %h expected 0", rdata);
    end
    reset = 0;
  endtask

  task automatic test_core_read;
    mem_arr[10'h10] = 32'hDEADBEEF;
    req0 = 1; we0 = 0; addr0 = 32'h10; wdata0 = 0;
    for (int c = 1; c <= 6; c++) begin
      tick;
      tests++;
      if (mem_en !== (c == 1)) begin
        fails++; $display("FAIL read_mem_en c%0d: got %b expected %b", c, mem_en, c == 1);
      end
      if (c == 1) begin
        tests++;
        if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
          fails++; $display("FAIL read_mem_req: got addr=%h we=%b expected 10/0", mem_addr, mem_we);
        end
      end
      tests++;
      if (ack0 !== (c == 4) || ack1 !== 1'b0) begin
        fails++; $display("FAIL read_ack c%0d: got %b%b expected %b0", c, ack0, ack1, c == 4);
      end
      if (c == 4) begin
        tests++;
        if (rdata !== 32'hDEADBEEF) begin
          fails++; $display("FAIL read_rdata: got %h expected deadbeef", rdata);
        end
      end
      if (ack0) req0 = 0;
    end
  endtask

  task automatic test_tie;
    do_reset;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h30; addr1 = 32'h40;
    for (int c = 1; c <= 12; c++) begin
      tick;
      tests++;
      if (ack0 !== (c == 4) || ack1 !== (c == 9)) begin
        fails++; $display("FAIL tie_ack c%0d: got %b%b expected %b%b", c, ack0, ack1, c == 4, c == 9);
      end
      if (c == 1 || c == 6) begin
        tests++;
        if (gnt_id !== (c == 6)) begin
          fails++; $display("FAIL tie_gnt c%0d: got %b expected %b", c, gnt_id, c == 6);
        end
      end
      if (c == 4 || c == 9) begin
        tests++;
        if (rdata !== f(c == 4 ? 32'h30 : 32'h40)) begin
          fails++; $display("FAIL tie_rdata c%0d: got %h expected %h", c, rdata, f(c == 4 ? 32'h30 : 32'h40));
        end
      end
      if (ack0) req0 = 0;
      if (ack1) req1 = 0;
    end
  endtask

  task automatic test_contention;
    int n = 0, n0 = 0, n1 = 0;
    logic exp_g = 0;
    req0 = 1; req1 = 1; addr0 = 32'h60; addr1 = 32'h70;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick;
      if (ack0 | ack1) begin
        tests++;
        if (ack0 === ack1 || ack1 !== exp_g || gnt_id !== exp_g) begin
          fails++; $display("FAIL contention_order #%0d: got ack=%b%b gnt=%b expected port %b", n, ack0, ack1, gnt_id, exp_g);
        end
        n0 += int'(ack0); n1 += int'(ack1);
        exp_g = ~exp_g;
        n++;
      end
    end
    req0 = 0; req1 = 0;
    tick;
    tests++;
    if (n0 != 2 || n1 != 2) begin
      fails++; $display("FAIL contention_count: got %0d/%0d expected 2/2", n0, n1);
    end
  endtask

  task automatic test_loader_write;
    int seen = 0, ens = 0;
    mem_arr[10'h20] = 32'hCAFEF00D;
    req0 = 1; we0 = 0; addr0 = 32'h20;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick;
      if (ack0) begin seen = 1; req0 = 0; end
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL lw_setup_read: got no ack0 expected ack0");
    end
    tick;
    req1 = 1; we1 = 1; addr1 = 32'h100; wdata1 = 32'h12345678;
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (mem_en) begin
        ens++;
        tests++;
        if (c != 1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h12345678) begin
          fails++; $display("FAIL lw_mem c%0d: got we=%b addr=%h wdata=%h expected c1 1/100/12345678", c, mem_we, mem_addr, mem_wdata);
        end
      end
      tests++;
      if (ack1 !== (c == 4) || ack0 !== 1'b0) begin
        fails++; $display("FAIL lw_ack c%0d: got %b%b expected 0%b", c, ack0, ack1, c == 4);
      end
      if (c == 4) begin
        tests++;
        if (rdata !== 32'hCAFEF00D) begin
          fails++; $display("FAIL lw_rdata_kept: got %h expected cafef00d", rdata);
        end
      end
      if (ack1) begin req1 = 0; we1 = 0; end
    end
    tests++;
    if (ens != 1 || mem_arr[10'h100] !== 32'h12345678) begin
      fails++; $display("FAIL lw_stored: got ens=%0d mem=%h expected 1/12345678", ens, mem_arr[10'h100]);
    end
  endtask

  task automatic test_reset_mid;
    int acks = 0, seen = 0;
    do_reset;
    req0 = 1; we0 = 0; addr0 = 32'h10;
    for (int c = 1; c <= 3; c++) tick;
    reset = 1; req0 = 0;
    tick;
    tests++;
    if (busy !== 1'b0 || mem_en !== 1'b0 || ack0 !== 1'b0) begin
      fails++; $display("FAIL rmid_state: got busy=%b en=%b ack0=%b expected 000", busy, mem_en, ack0);
    end
    reset = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      acks += int'(ack0 | ack1);
    end
    tests++;
    if (acks != 0) begin
      fails++; $display("FAIL rmid_no_ack: got %0d acks expected 0", acks);
    end
    req0 = 1; req1 = 1; addr0 = 32'h30; addr1 = 32'h40;
    for (int c = 0; c < 12 && !seen; c++) begin
      tick;
      if (ack0 | ack1) begin
        seen = 1;
        tests++;
        if (ack0 !== 1'b1 || gnt_id !== 1'b0) begin
          fails++; $display("FAIL rmid_core_first: got ack0=%b gnt=%b expected 1/0", ack0, gnt_id);
        end
        req0 = 0; req1 = 0;
      end
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL rmid_timeout: got no ack expected ack");
    end
    tick;
  endtask

  task automatic test_early_drop;
    req0 = 1; we0 = 0; addr0 = 32'h50;
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (c == 1) req0 = 0;
      tests++;
      if (ack0 !== (c == 4)) begin
        fails++; $display("FAIL drop_ack c%0d: got %b expected %b", c, ack0, c == 4);
      end
      if (c == 4) begin
        tests++;
        if (rdata !== f(32'h50)) begin
          fails++; $display("FAIL drop_rdata: got %h expected %h", rdata, f(32'h50));
        end
      end
    end
  endtask

  // model: each grant fixes its mem_en and ack cycles; the port frees up LAT+3 cycles after sampling
  task automatic test_random;
    bit pend = 0, p_port = 0, p_we = 0, mlast = 1, g, e_a0, e_a1, e_en;
    int en_at = 0, ack_at = 0, free_at = 0, a;
    logic [31:0] p_addr = 0, p_wd = 0, p_rd = 0;
    do_reset;
    for (int t = 0; t < 400; t++) begin
      e_a0 = pend && t == ack_at && !p_port;
      e_a1 = pend && t == ack_at && p_port;
      e_en = pend && t == en_at;
      tests++;
      if (ack0 !== e_a0 || ack1 !== e_a1) begin
        fails++; $display("FAIL rand_ack t%0d: got %b%b expected %b%b", t, ack0, ack1, e_a0, e_a1);
      end
      tests++;
      if (mem_en !== e_en || busy !== (pend && t >= en_at)) begin
        fails++; $display("FAIL rand_en_busy t%0d: got %b%b expected %b%b", t, mem_en, busy, e_en, pend && t >= en_at);
      end
      if (e_en) begin
        tests++;
        if (mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_wd || gnt_id !== p_port) begin
          fails++; $display("FAIL rand_mem t%0d: got %b/%h/%h/%b expected %b/%h/%h/%b", t, mem_we, mem_addr, mem_wdata, gnt_id, p_we, p_addr, p_wd, p_port);
        end
      end
      if ((e_a0 || e_a1) && !p_we) begin
        tests++;
        if (rdata !== p_rd) begin
          fails++; $display("FAIL rand_rdata t%0d: got %h expected %h", t, rdata, p_rd);
        end
      end
      if (pend && t == ack_at) pend = 0;
      if (ack0) req0 = 0;
      else if (req0 && pend && !p_port) begin addr0 = $urandom; wdata0 = $urandom; we0 = $urandom; end
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; we0 = $urandom; addr0 = 32'h200 + $urandom_range(0, 15); wdata0 = $urandom;
      end
      if (ack1) req1 = 0;
      else if (req1 && pend && p_port) begin addr1 = $urandom; wdata1 = $urandom; we1 = $urandom; end
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; we1 = $urandom; addr1 = 32'h200 + $urandom_range(0, 15); wdata1 = $urandom;
      end
      if (!pend && t >= free_at && (req0 || req1)) begin
        g = (req0 && req1) ? !mlast : req1;
        mlast = g; p_port = g; pend = 1;
        en_at = t + 1; ack_at = t + LAT + 2; free_at = t + LAT + 3;
        p_we = g ? we1 : we0;
        p_addr = g ? addr1 : addr0;
        p_wd = g ? wdata1 : wdata0;
        a = int'(p_addr[9:0]);
        if (p_we) ref_mem[a] = p_wd;
        else p_rd = ref_mem[a];
      end
      tick;
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = f(i);
      ref_mem[i] = f(i);
    end
    test_reset;
    test_core_read;
    test_tie;
    test_contention;
    test_loader_write;
    test_reset_mid;
    test_early_drop;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
